// File: rtl/oam_dma_if.sv
// CPU-side bus and OAM write port of the sprite DMA engine, grouped for port connection.
// master drives the CPU bus inputs; slave is the DMA engine.
interface oam_dma_if;
  logic        cpu_ce;
  logic        reg_we;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  oam_start;
  logic [7:0]  dma_rdata;
  logic        cpu_halt;
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        busy;

  modport master (
    output cpu_ce, reg_we, reg_addr, reg_wdata, oam_start, dma_rdata,
    input  cpu_halt, dma_rd, dma_addr, oam_we, oam_addr, oam_wdata, busy
  );

  modport slave (
    input  cpu_ce, reg_we, reg_addr, reg_wdata, oam_start, dma_rdata,
    output cpu_halt, dma_rd, dma_addr, oam_we, oam_addr, oam_wdata, busy
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: a page-register write halts the CPU and copies 256 bytes {page,00..FF} into OAM from OAMADDR.
// 513/514 CPU cycles per transfer (get/put alignment); all progress is gated by cpu_ce, no other backpressure.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter int          XFER_LEN     = 256
) (
  input  logic     clock,
  input  logic     reset,
  oam_dma_if.slave bus
);

  localparam logic [8:0] LAST_IDX = 9'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        parity;
  logic [8:0]  idx;
  logic [7:0]  page;
  logic [7:0]  base;
  logic [7:0]  latch;
  logic        trigger;

  logic        active;
  logic        rd_strobe;
  logic        wr_strobe;
  logic [15:0] rd_addr;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;

  // Writes to the page register are only honoured from IDLE; retriggers mid-transfer are dropped.
  assign trigger = bus.cpu_ce & bus.reg_we & (bus.reg_addr == DMA_REG_ADDR) & (state == IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      parity <= 1'b0;
    end else if (bus.cpu_ce) begin
      state  <= state_nxt;
      parity <= ~parity;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx   <= '0;
      page  <= '0;
      base  <= '0;
      latch <= '0;
    end else if (trigger) begin
      idx  <= '0;
      page <= bus.reg_wdata;
      base <= bus.oam_start;
    end else if (bus.cpu_ce) begin
      if (state == READ) begin
        latch <= bus.dma_rdata;
      end
      if (state == WRITE) begin
        idx <= idx + 9'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    active    = (state != IDLE);
    rd_strobe = 1'b0;
    wr_strobe = 1'b0;
    rd_addr   = '0;
    wr_addr   = '0;
    wr_data   = '0;

    case (state)
      IDLE: begin
        if (trigger) begin
          state_nxt = HALT;
        end
      end
      // parity==0 here means the next cycle is a put, so burn one more to land READ on a get.
      HALT: begin
        state_nxt = parity ? READ : ALIGN;
      end
      ALIGN: begin
        state_nxt = READ;
      end
      READ: begin
        state_nxt = WRITE;
        rd_strobe = bus.cpu_ce;
        rd_addr   = {page, idx[7:0]};
      end
      WRITE: begin
        state_nxt = (idx == LAST_IDX) ? IDLE : READ;
        wr_strobe = bus.cpu_ce;
        wr_addr   = base + idx[7:0];
        wr_data   = latch;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.cpu_halt  = active;
  assign bus.busy      = active;
  assign bus.dma_rd    = rd_strobe;
  assign bus.dma_addr  = rd_addr;
  assign bus.oam_we    = wr_strobe;
  assign bus.oam_addr  = wr_addr;
  assign bus.oam_wdata = wr_data;

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma: each transfer is compared against an address/length model of the copy.
module tb_oam_dma;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   ce_cnt;
  int   trig_odd;
  bit   rd_hash;
  logic [7:0] rd_seed;

  logic        s_halt;
  logic        s_busy;
  logic        s_rd;
  logic [15:0] s_addr;
  logic        s_we;
  logic [7:0]  s_oaddr;
  logic [7:0]  s_odata;

  oam_dma_if bus ();

  oam_dma u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Source memory contents as seen by the DMA read port.
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    logic [7:0] hi;
    hi = a[15:8];
    if (!rd_hash) return a[7:0];
    return a[7:0] ^ (hi * 8'h3B) ^ rd_seed;
  endfunction

  always_comb bus.dma_rdata = src_byte(bus.dma_addr);

  // One CPU cycle, optionally preceded by cpu_ce-low clocks; outputs sampled on the falling edge.
  task automatic ce_tick(input int stall, input logic we, input logic [15:0] addr, input logic [7:0] wd);
    for (int i = 0; i < stall; i++) begin
      bus.cpu_ce = 1'b0;
      bus.reg_we = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.dma_rd !== 1'b0 || bus.oam_we !== 1'b0) begin
        errors++;
        $display("FAIL stall_strobe: dma_rd=%b oam_we=%b required 0/0", bus.dma_rd, bus.oam_we);
      end
      @(posedge clock);
      #1;
    end
    bus.cpu_ce    = 1'b1;
    bus.reg_we    = we;
    bus.reg_addr  = addr;
    bus.reg_wdata = wd;
    @(negedge clock);
    s_halt  = bus.cpu_halt;
    s_busy  = bus.busy;
    s_rd    = bus.dma_rd;
    s_addr  = bus.dma_addr;
    s_we    = bus.oam_we;
    s_oaddr = bus.oam_addr;
    s_odata = bus.oam_wdata;
    @(posedge clock);
    #1;
    ce_cnt++;
    bus.cpu_ce = 1'b0;
    bus.reg_we = 1'b0;
  endtask

  task automatic do_xfer(input logic [7:0] pg, input logic [7:0] st, input int want_odd, input int max_stall,
                         input int retrig_byte, input int abort_byte, input bit chain,
                         input logic [7:0] chain_pg, input logic [7:0] chain_st, input bit pretrig);
    int halt_n, nrd, nwr, first_rd, exp_len, cyc, stall;
    bit done, retrig_done;
    logic we;
    logic [15:0] addr;
    logic [7:0] wd, exp_oaddr;
    halt_n = 0; nrd = 0; nwr = 0; first_rd = -1; cyc = 0;
    done = 0; retrig_done = 0;
    if (!pretrig) begin
      if ((ce_cnt % 2) != want_odd) ce_tick(0, 1'b0, 16'h0000, 8'h00);
      trig_odd = ce_cnt % 2;
      bus.oam_start = st;
      ce_tick(0, 1'b1, 16'h4014, pg);
      checks++;
      if (s_halt !== 1'b0) begin
        errors++;
        $display("FAIL trigger_cycle_idle: cpu_halt=%b required 0", s_halt);
      end
    end
    exp_len = (trig_odd != 0) ? 514 : 513;
    bus.oam_start = 8'($urandom);
    while (!done && cyc < 1200) begin
      we = 1'b0;
      addr = 16'($urandom);
      wd = 8'($urandom);
      if (retrig_byte >= 0 && !retrig_done && nwr == retrig_byte) begin
        we = 1'b1; addr = 16'h4014; wd = 8'h05; retrig_done = 1;
      end
      if (chain && halt_n == exp_len) begin
        we = 1'b1; addr = 16'h4014; wd = chain_pg;
        trig_odd = ce_cnt % 2;
        bus.oam_start = chain_st;
      end
      stall = 0;
      if (max_stall > 0 && $urandom_range(0, 2) == 0) stall = $urandom_range(1, max_stall);
      ce_tick(stall, we, addr, wd);
      cyc++;
      if (!s_halt) begin
        done = 1;
      end else begin
        halt_n++;
        checks++;
        if (s_busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_tracks_halt: busy=%b required 1", s_busy);
        end
      end
      checks++;
      if (s_rd && s_we) begin
        errors++;
        $display("FAIL one_strobe: dma_rd=%b oam_we=%b required not both", s_rd, s_we);
      end
      if (s_rd) begin
        if (first_rd < 0) first_rd = halt_n;
        checks++;
        if (s_addr !== {pg, 8'(nrd)}) begin
          errors++;
          $display("FAIL dma_addr[%0d]: got %h required %h", nrd, s_addr, {pg, 8'(nrd)});
        end
        nrd++;
      end
      if (s_we) begin
        exp_oaddr = st + 8'(nwr);
        checks++;
        if (s_oaddr !== exp_oaddr || s_odata !== src_byte({pg, 8'(nwr)})) begin
          errors++;
          $display("FAIL oam_write[%0d]: got addr %h data %h required addr %h data %h",
                   nwr, s_oaddr, s_odata, exp_oaddr, src_byte({pg, 8'(nwr)}));
        end
        nwr++;
        if (abort_byte >= 0 && nwr == abort_byte) begin
          reset = 1'b0;
          #1;
          checks++;
          if (bus.cpu_halt !== 1'b0 || bus.busy !== 1'b0 || bus.oam_we !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: halt=%b busy=%b oam_we=%b required 0/0/0", bus.cpu_halt, bus.busy, bus.oam_we);
          end
          repeat (4) begin
            bus.cpu_ce = 1'b1;
            @(negedge clock);
            checks++;
            if (bus.oam_we !== 1'b0 || bus.dma_rd !== 1'b0 || bus.cpu_halt !== 1'b0) begin
              errors++;
              $display("FAIL abort_quiet: oam_we=%b dma_rd=%b halt=%b required 0/0/0", bus.oam_we, bus.dma_rd, bus.cpu_halt);
            end
            @(posedge clock);
            #1;
          end
          bus.cpu_ce = 1'b0;
          reset = 1'b1;
          ce_cnt = 0;
          return;
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL xfer_timeout: halt still high after %0d cycles, required drop", cyc);
    end
    checks++;
    if (halt_n != exp_len) begin
      errors++;
      $display("FAIL halt_length: got %0d required %0d", halt_n, exp_len);
    end
    checks++;
    if (nrd != 256 || nwr != 256) begin
      errors++;
      $display("FAIL strobe_counts: reads %0d writes %0d required 256/256", nrd, nwr);
    end
    checks++;
    if (first_rd != ((trig_odd != 0) ? 3 : 2)) begin
      errors++;
      $display("FAIL first_read_slot: got %0d required %0d", first_rd, (trig_odd != 0) ? 3 : 2);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      bus.cpu_ce    = i[0];
      bus.reg_we    = 1'b1;
      bus.reg_addr  = 16'h4014;
      bus.reg_wdata = 8'h02;
      @(negedge clock);
      checks++;
      if ({bus.cpu_halt, bus.busy, bus.dma_rd, bus.oam_we} !== 4'b0 || bus.dma_addr !== 16'h0 ||
          bus.oam_addr !== 8'h0 || bus.oam_wdata !== 8'h0) begin
        errors++;
        $display("FAIL reset_outputs: halt=%b busy=%b rd=%b we=%b addr=%h oaddr=%h odata=%h required all 0",
                 bus.cpu_halt, bus.busy, bus.dma_rd, bus.oam_we, bus.dma_addr, bus.oam_addr, bus.oam_wdata);
      end
    end
    @(posedge clock);
    #1;
    bus.cpu_ce = 1'b0;
    bus.reg_we = 1'b0;
    reset = 1'b1;
    ce_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      ce_tick(0, 1'b0, 16'h4014, 8'h00);
      checks++;
      if (s_halt !== 1'b0 || s_rd !== 1'b0 || s_we !== 1'b0) begin
        errors++;
        $display("FAIL reset_write_ignored: halt=%b rd=%b we=%b required 0/0/0", s_halt, s_rd, s_we);
      end
    end
  endtask

  task automatic test_even;
    rd_hash = 0;
    do_xfer(8'h02, 8'h00, 0, 0, -1, -1, 0, 8'h00, 8'h00, 0);
  endtask

  task automatic test_odd;
    rd_hash = 0;
    do_xfer(8'h02, 8'h00, 1, 0, -1, -1, 0, 8'h00, 8'h00, 0);
  endtask

  task automatic test_wrap;
    rd_hash = 1;
    rd_seed = 8'($urandom);
    do_xfer(8'h03, 8'hF0, int'($urandom_range(0, 1)), 0, -1, -1, 0, 8'h00, 8'h00, 0);
  endtask

  task automatic test_retrigger;
    rd_hash = 1;
    rd_seed = 8'($urandom);
    do_xfer(8'h03, 8'($urandom), int'($urandom_range(0, 1)), 0, 100, -1, 0, 8'h00, 8'h00, 0);
  endtask

  task automatic test_stall_reset;
    rd_hash = 1;
    rd_seed = 8'($urandom);
    do_xfer(8'($urandom), 8'($urandom), int'($urandom_range(0, 1)), 3, -1, -1, 0, 8'h00, 8'h00, 0);
    do_xfer(8'($urandom), 8'($urandom), int'($urandom_range(0, 1)), 3, -1, 40, 0, 8'h00, 8'h00, 0);
    do_xfer(8'($urandom), 8'($urandom), 0, 0, -1, -1, 0, 8'h00, 8'h00, 0);
    do_xfer(8'($urandom), 8'($urandom), 1, 2, -1, -1, 0, 8'h00, 8'h00, 0);
  endtask

  task automatic test_back_to_back;
    rd_hash = 1;
    rd_seed = 8'($urandom);
    do_xfer(8'h11, 8'h80, 0, 0, -1, -1, 1, 8'hFF, 8'h01, 0);
    do_xfer(8'hFF, 8'h01, 0, 0, -1, -1, 0, 8'h00, 8'h00, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ce_cnt = 0;
    trig_odd = 0;
    rd_hash = 0;
    rd_seed = 8'h00;
    reset = 1'b0;
    bus.cpu_ce = 1'b0;
    bus.reg_we = 1'b0;
    bus.reg_addr = 16'h0000;
    bus.reg_wdata = 8'h00;
    bus.oam_start = 8'h00;
    test_reset;
    test_even;
    test_odd;
    test_wrap;
    test_retrigger;
    test_stall_reset;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
